// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory among four cores,
// with bounded lock sequences for read-modify-write.
module data_mem_arbiter #(
  parameter int unsigned NCORES   = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES-1:0]    lock,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    rvalid,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int unsigned IW = 2;
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  logic [IW-1:0]     r_last;
  logic              r_owner_valid;
  logic [IW-1:0]     r_owner;
  logic [CW-1:0]     r_lock_cnt;
  logic [NCORES-1:0] r_rd_pend;
  logic [AW-1:0]     r_addr;

  logic              w_any;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_idx;
  logic [CW-1:0]     w_base;
  logic              w_lock_take;

  // Lock owner wins outright; otherwise scan upward from the core after the last winner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    if (!reset) begin
      if (r_owner_valid && req[r_owner]) begin
        w_any = 1'b1;
        w_win = r_owner;
      end else begin
        for (int k = 1; k <= int'(NCORES); k++) begin
          w_idx = r_last + IW'(k);
          if (!w_any && req[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
          end
        end
      end
    end
  end

  always_comb begin
    gnt       = w_any ? (NCORES'(1) << w_win) : '0;
    mem_addr  = w_any ? addr[w_win*AW +: AW] : r_addr;
    mem_we    = w_any && we[w_win];
    mem_wdata = w_any ? wdata[w_win*DW +: DW] : '0;
    rvalid    = r_rd_pend & {NCORES{~reset}};
    rdata     = mem_rdata;
  end

  // A winner that is not the current owner starts a fresh lock run.
  always_comb begin
    w_base      = (r_owner_valid && (r_owner == w_win)) ? r_lock_cnt : '0;
    w_lock_take = w_any && lock[w_win] && (w_base < CW'(MAX_LOCK - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last        <= IW'(NCORES - 1);
      r_owner_valid <= 1'b0;
      r_owner       <= '0;
      r_lock_cnt    <= '0;
      r_rd_pend     <= '0;
      r_addr        <= '0;
    end else begin
      if (w_any) begin
        r_last <= w_win;
        r_addr <= mem_addr;
      end
      if (w_lock_take) begin
        r_owner_valid <= 1'b1;
        r_owner       <= w_win;
        r_lock_cnt    <= w_base + CW'(1);
      end else begin
        r_owner_valid <= 1'b0;
        r_lock_cnt    <= '0;
      end
      r_rd_pend <= gnt & ~we;
    end
  end

endmodule
